ark_round_sequencer: RTL and testbench
======================================

# ark_round_sequencer

Byte-serial sequencer for the 8-bit AddRoundKey lane of the AES core. On `start` it walks all 16 state bytes through the XOR with the matching round-key bytes, once per round, for rounds 0..NR. The state lives in an external dual-port byte RAM and the expanded key in an external key RAM. Between rounds it hands the state to the SubBytes/ShiftRows/MixColumns unit through a req/ack handshake. It sits between the AHB-facing control registers and the byte datapath.

## Interface
- `NR`, 10 — number of rounds (10/12/14); round counter runs 0..NR.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle request to run a full encryption pass; ignored while `busy`.
- `busy` out 1 — high from the cycle after `start` is accepted until the cycle `done` is high, inclusive.
- `done` out 1 — one-cycle pulse after the final AddRoundKey write of round NR.
- `st_rd` out 1 — state RAM read strobe.
- `st_addr` out 4 — state RAM read byte index.
- `st_rdata` in 8 — state byte; valid one cycle after `st_rd`.
- `st_we` out 1 — state RAM write strobe.
- `st_waddr` out 4 — state RAM write byte index.
- `st_wdata` out 8 — `st_rdata ^ key_rdata`.
- `key_rd` out 1 — key RAM read strobe; always equal to `st_rd`.
- `key_addr` out 8 — `round*16 + byte index`.
- `key_rdata` in 8 — key byte; valid one cycle after `key_rd`.
- `xf_req` out 1 — request round transform for round `xf_round`.
- `xf_round` out 4 — round about to be keyed (1..NR); NR means "final round, no MixColumns".
- `xf_ack` in 1 — transform complete; accepted only while `xf_req` is high.

## Operation
- Byte order: index 0 is bits [127:120], MSB first.
- The FSM has four states: IDLE, ARK, DRAIN, XFORM.
  - IDLE: `start` moves to ARK with round=0, idx=0.
  - ARK: one read per cycle (`st_rd`/`key_rd` = 1, `st_addr` = idx). After idx=15, move to DRAIN.
  - DRAIN: one cycle in which the idx=15 write completes. Then:
    - if round<NR, move to XFORM;
    - otherwise pulse `done` and return to IDLE.
  - XFORM: `xf_req` = 1 and `xf_round` = round+1, held until `xf_ack`. On ack: round+1, idx=0, move to ARK. The next ARK read cycle follows the ack cycle directly.
- Write pipeline: `st_we`/`st_waddr` are the registered copies of `st_rd`/`st_addr`, and `st_wdata` is combinational XOR of the input data.
  - Every read produces exactly one write, one cycle later.
  - No write is ever issued without a preceding read.
- `key_addr` width rule: round (4b) concatenated with idx (4b). Maximum is 14*16+15 = 239, so there is no overflow.
- `start` while busy, and `xf_ack` outside XFORM, are ignored with no side effects.
- `start` and `done` in the same cycle: `start` is ignored, because `busy` is still high that cycle.

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `st_rd`, `st_we`, `key_rd`, `xf_req` low; addresses, `xf_round`, `st_wdata` register 0). State is IDLE, round=0, idx=0.
- Cycle-level sequence, with `start` sampled at cycle 0:
  - reads at cycles 1..16;
  - writes at cycles 2..17;
  - `xf_req` rises at cycle 18.
- Each round costs 17 cycles plus the XFORM wait (minimum 1 cycle). With `xf_ack` held high, round k reads start at cycle 1+18k.
- NR=10 with zero-wait ack: `done` at cycle 198.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. A pending write is dropped, and the state RAM contents are undefined to software.

## Configuration
- `ARK_KEY_CHECKSUM_EN` defined: adds output `key_xsum` (8b). It is the running XOR of every `key_rdata` byte consumed in the current pass. It clears on accepted `start` and is stable from `done` until the next `start`. It lets software cross-check the key schedule.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `aes_ctrl_pkg`:
  - FSM state enum `ark_state_t` (IDLE, ARK, DRAIN, XFORM);
  - `AES_NB_BYTES = 16`;
  - `AES_KEY_AW = 8`;
  - `AES_RND_W = 4`.
- No sub-module: the single-byte XOR lane is inline. Counters and FSM stay in one module.

## Test plan
- Round-0 vector: NR=0 simulation variant, state RAM 00112233445566778899aabbccddeeff, key bytes 00..0f → RAM 00102030405060708090a0b0c0d0e0f0, `done` at cycle 18.
- Full NR=10 pass with `xf_ack` tied high → `xf_round` sequence 1..10, `key_addr` spans 0..175 contiguous, `done` at cycle 198, exactly 176 writes.
- `xf_ack` delayed 5 cycles in round 3 → `xf_req` held for all 5 cycles, no reads or writes during the wait, `done` delayed by exactly 5.
- `start` pulsed mid-pass and `xf_ack` pulsed in ARK → ignored; `key_addr` sequence and `done` timing unchanged.
- `rst` asserted during a write cycle of round 2 → next cycle all outputs 0 and `busy` low; a following `start` runs a full correct pass from round 0.
- With `ARK_KEY_CHECKSUM_EN`: key bytes 00..0f in round 0 (NR=0) → `key_xsum` = 00.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared AES control definitions: the AddRoundKey sequencer state encoding
// and the byte, key-address and round widths.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARK   = 2'd1,
        DRAIN = 2'd2,
        XFORM = 2'd3
    } ark_state_t;

    localparam int AES_NB_BYTES = 16;
    localparam int AES_KEY_AW   = 8;
    localparam int AES_RND_W    = 4;

endpackage

// File: rtl/ark_round_sequencer.sv
// Byte-serial AddRoundKey sequencer: walks 16 state bytes per round against the key RAM.
// Optional feature macro ARK_KEY_CHECKSUM_EN adds key_xsum, a running XOR of consumed key bytes.
module ark_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  st_rd,
    output logic [3:0]            st_addr,
    input  logic [7:0]            st_rdata,
    output logic                  st_we,
    output logic [3:0]            st_waddr,
    output logic [7:0]            st_wdata,
    output logic                  key_rd,
    output logic [AES_KEY_AW-1:0] key_addr,
    input  logic [7:0]            key_rdata,
    output logic                  xf_req,
    output logic [AES_RND_W-1:0]  xf_round,
    input  logic                  xf_ack,
`ifdef ARK_KEY_CHECKSUM_EN
    output logic [7:0]            key_xsum,
`endif
    output logic [1:0]            dbg_state
);

    localparam logic [AES_RND_W-1:0] LP_NR       = AES_RND_W'(NR);
    localparam logic [3:0]           LP_LAST_IDX = 4'(AES_NB_BYTES - 1);

    ark_state_t             r_state;
    logic [AES_RND_W-1:0]   r_round;
    logic [3:0]             r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_st_rd;
    logic                   r_st_we;
    logic [3:0]             r_st_waddr;
    logic                   r_xf_req;
    logic [AES_RND_W-1:0]   r_xf_round;
    logic                   w_start_acc;

    // busy stays high through the done cycle, so a start there is not accepted
    assign w_start_acc = (r_state == IDLE) && !r_busy && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_round    <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_st_rd    <= 1'b0;
            r_st_we    <= 1'b0;
            r_st_waddr <= '0;
            r_xf_req   <= 1'b0;
            r_xf_round <= '0;
        end else begin
            r_st_we    <= r_st_rd;
            r_st_waddr <= r_idx;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (w_start_acc) begin
                        r_busy  <= 1'b1;
                        r_round <= '0;
                        r_idx   <= '0;
                        r_st_rd <= 1'b1;
                        r_state <= ARK;
                    end
                end
                ARK: begin
                    if (r_idx == LP_LAST_IDX) begin
                        r_st_rd <= 1'b0;
                        r_idx   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                DRAIN: begin
                    if (r_round == LP_NR) begin
                        r_done  <= 1'b1;
                        r_round <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_xf_req   <= 1'b1;
                        r_xf_round <= r_round + 1'b1;
                        r_state    <= XFORM;
                    end
                end
                XFORM: begin
                    if (xf_ack) begin
                        r_xf_req   <= 1'b0;
                        r_xf_round <= '0;
                        r_round    <= r_round + 1'b1;
                        r_idx      <= '0;
                        r_st_rd    <= 1'b1;
                        r_state    <= ARK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARK_KEY_CHECKSUM_EN
    logic [7:0] r_key_xsum;

    // each write consumes exactly one key byte
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_key_xsum <= '0;
        end else if (r_st_we) begin
            r_key_xsum <= r_key_xsum ^ key_rdata;
        end
    end

    assign key_xsum = r_key_xsum;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign st_rd     = r_st_rd;
    assign key_rd    = r_st_rd;
    assign st_addr   = r_idx;
    assign key_addr  = {r_round, r_idx};
    assign st_we     = r_st_we;
    assign st_waddr  = r_st_waddr;
    assign st_wdata  = r_st_we ? (st_rdata ^ key_rdata) : 8'h00;
    assign xf_req    = r_xf_req;
    assign xf_round  = r_xf_round;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ark_round_sequencer.sv
// Bench for ark_round_sequencer: an NR=10 instance for full passes and an NR=0
// instance for the single-round vector, each backed by simple byte-RAM models.
module tb_ark_round_sequencer;

    localparam int NR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, xf_ack;
    logic       busy, done, st_rd, st_we, key_rd, xf_req;
    logic [3:0] st_addr, st_waddr, xf_round;
    logic [7:0] st_rdata, st_wdata, key_addr, key_rdata;
    logic [1:0] dbg_state;
    logic [7:0] key_xsum;

    logic       start_z, xf_ack_z;
    logic       busy_z, done_z, st_rd_z, st_we_z, key_rd_z, xf_req_z;
    logic [3:0] st_addr_z, st_waddr_z, xf_round_z;
    logic [7:0] st_rdata_z, st_wdata_z, key_addr_z, key_rdata_z;
    logic [1:0] dbg_state_z;
    logic [7:0] key_xsum_z;

`ifndef ARK_KEY_CHECKSUM_EN
    assign key_xsum   = 8'h00;
    assign key_xsum_z = 8'h00;
`endif

    ark_round_sequencer #(.NR(NR)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .st_rd(st_rd), .st_addr(st_addr), .st_rdata(st_rdata),
        .st_we(st_we), .st_waddr(st_waddr), .st_wdata(st_wdata),
        .key_rd(key_rd), .key_addr(key_addr), .key_rdata(key_rdata),
        .xf_req(xf_req), .xf_round(xf_round), .xf_ack(xf_ack),
`ifdef ARK_KEY_CHECKSUM_EN
        .key_xsum(key_xsum),
`endif
        .dbg_state(dbg_state)
    );

    ark_round_sequencer #(.NR(0)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z), .busy(busy_z), .done(done_z),
        .st_rd(st_rd_z), .st_addr(st_addr_z), .st_rdata(st_rdata_z),
        .st_we(st_we_z), .st_waddr(st_waddr_z), .st_wdata(st_wdata_z),
        .key_rd(key_rd_z), .key_addr(key_addr_z), .key_rdata(key_rdata_z),
        .xf_req(xf_req_z), .xf_round(xf_round_z), .xf_ack(xf_ack_z),
`ifdef ARK_KEY_CHECKSUM_EN
        .key_xsum(key_xsum_z),
`endif
        .dbg_state(dbg_state_z)
    );

    // RAM models: state preloads to 00 11 22 .. ff, key byte value equals its address
    logic [7:0] mem   [16];
    logic [7:0] mem_z [16];
    logic       ram_load, ram_load_z;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
        end else if (st_we) begin
            mem[st_waddr] <= st_wdata;
        end
        if (st_rd)  st_rdata  <= mem[st_addr];
        if (key_rd) key_rdata <= key_addr;
    end

    always @(posedge clk) begin
        if (ram_load_z) begin
            for (int i = 0; i < 16; i++) mem_z[i] <= 8'(i * 17);
        end else if (st_we_z) begin
            mem_z[st_waddr_z] <= st_wdata_z;
        end
        if (st_rd_z)  st_rdata_z  <= mem_z[st_addr_z];
        if (key_rd_z) key_rdata_z <= key_addr_z;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int ack_round;
        int ack_delay;
        bit ack_idle;
        int stray_start;
        int stray_ack;
        bit start_at_done;
        int exp_done;
        int exp_writes;
    } vec_t;

    logic [7:0]  exp_rd_q [$];
    logic [11:0] exp_wr_q [$];
    logic [3:0]  exp_xf_q [$];

    task automatic run_pass(input vec_t v);
        int         rel, wait_cnt, nwr, first_rd, first_we, first_xf, done_rel;
        logic       xf_q;
        logic [7:0] run [16];
        logic [7:0] e, xs;
        logic [11:0] w;
        logic [3:0] xr;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_xf_q.delete();
        xs = 8'h00;
        for (int i = 0; i < 16; i++) run[i] = 8'(i * 17);
        for (int r = 0; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) begin
                exp_rd_q.push_back(8'(r * 16 + i));
                run[i] = run[i] ^ 8'(r * 16 + i);
                xs = xs ^ 8'(r * 16 + i);
                exp_wr_q.push_back({4'(i), run[i]});
            end
            if (r > 0) exp_xf_q.push_back(4'(r));
        end
        @(negedge clk); ram_load = 1'b1;
        @(negedge clk); ram_load = 1'b0;
        start = 1'b1; xf_ack = v.ack_idle;
        rel = 0; wait_cnt = 0; nwr = 0; xf_q = 1'b0;
        first_rd = -1; first_we = -1; first_xf = -1; done_rel = -1;
        while (rel < 600 && (done_rel < 0 || rel < done_rel + 2)) begin
            @(negedge clk);
            rel++;
            if (st_rd) begin
                if (first_rd < 0) first_rd = rel;
                chk("key_rd with st_rd", {31'd0, key_rd}, 32'd1);
                if (exp_rd_q.size() == 0) chk("unexpected read", {24'd0, key_addr}, 32'hffff);
                else begin
                    e = exp_rd_q.pop_front();
                    chk("read address", {20'd0, st_addr, key_addr}, {20'd0, e[3:0], e});
                end
            end
            if (st_we) begin
                nwr++;
                if (first_we < 0) first_we = rel;
                if (exp_wr_q.size() == 0) chk("unexpected write", {20'd0, st_waddr, st_wdata}, 32'hffff);
                else begin
                    w = exp_wr_q.pop_front();
                    chk("write addr/data", {20'd0, st_waddr, st_wdata}, {20'd0, w});
                end
            end
            if (xf_req && !xf_q) begin
                if (first_xf < 0) first_xf = rel;
                if (exp_xf_q.size() == 0) chk("unexpected xf_req", {28'd0, xf_round}, 32'hff);
                else begin
                    xr = exp_xf_q.pop_front();
                    chk("xf_round", {28'd0, xf_round}, {28'd0, xr});
                end
            end
            if (xf_req) chk("no ram access in xform", {30'd0, st_rd, st_we}, 32'd0);
            xf_q = xf_req;
            if (rel == 1) chk("busy after start", {31'd0, busy}, 32'd1);
            if (done && done_rel < 0) begin
                done_rel = rel;
                chk("busy in done cycle", {31'd0, busy}, 32'd1);
            end
            if (done_rel > 0 && rel > done_rel) chk("idle after done", {30'd0, busy, st_rd}, 32'd0);
            start = (rel == v.stray_start) || (v.start_at_done && done);
            if (xf_req) begin
                if (int'(xf_round) == v.ack_round && wait_cnt < v.ack_delay) begin
                    xf_ack = 1'b0;
                    wait_cnt++;
                end else begin
                    xf_ack = 1'b1;
                end
            end else begin
                xf_ack = v.ack_idle || (rel == v.stray_ack);
            end
        end
        start = 1'b0; xf_ack = 1'b0;
        chk("done cycle", done_rel, v.exp_done);
        chk("write count", nwr, v.exp_writes);
        chk("first read cycle", first_rd, 1);
        chk("first write cycle", first_we, 2);
        chk("first xf_req cycle", first_xf, 18);
        chk("reads left", exp_rd_q.size(), 0);
        chk("writes left", exp_wr_q.size(), 0);
        chk("xforms left", exp_xf_q.size(), 0);
        for (int i = 0; i < 16; i++) chk("final state byte", {24'd0, mem[i]}, {24'd0, run[i]});
`ifdef ARK_KEY_CHECKSUM_EN
        chk("key_xsum full pass", {24'd0, key_xsum}, {24'd0, xs});
`endif
    endtask

    vec_t        tbl [4];
    logic [127:0] r0_vec;
    int          rel, done_rel, nwr;

    initial begin
        tbl[0] = '{0,  0, 1'b1, -1, -1, 1'b0, 198, 176};
        tbl[1] = '{3,  5, 1'b0, -1, -1, 1'b0, 203, 176};
        tbl[2] = '{0,  0, 1'b0, 50,  5, 1'b1, 198, 176};
        tbl[3] = '{10, 3, 1'b0, -1, -1, 1'b1, 201, 176};
        r0_vec = 128'h00102030405060708090a0b0c0d0e0f0;

        rst = 1'b1; start = 1'b0; xf_ack = 1'b0; start_z = 1'b0; xf_ack_z = 1'b1;
        ram_load = 1'b0; ram_load_z = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, st_rd, st_we, key_rd, xf_req, st_addr, st_waddr,
                              st_wdata, key_addr, xf_round}, 32'd0);
        chk("reset state/xsum", {22'd0, dbg_state, key_xsum}, 32'd0);
        chk("reset outputs nr0", {busy_z, done_z, st_rd_z, st_we_z, key_rd_z, xf_req_z,
                                  st_addr_z, st_waddr_z, st_wdata_z, key_addr_z, xf_round_z}, 32'd0);
        rst = 1'b0;

        // single-round pass on the NR=0 instance
        @(negedge clk); ram_load_z = 1'b1;
        @(negedge clk); ram_load_z = 1'b0; start_z = 1'b1;
        rel = 0; done_rel = -1; nwr = 0;
        while (rel < 60 && done_rel < 0) begin
            @(negedge clk);
            rel++;
            start_z = 1'b0;
            if (st_we_z) nwr++;
            if (xf_req_z) chk("no xform when NR=0", {31'd0, xf_req_z}, 32'd0);
            if (done_z) done_rel = rel;
        end
        chk("nr0 done cycle", done_rel, 18);
        chk("nr0 write count", nwr, 16);
        for (int i = 0; i < 16; i++)
            chk("nr0 state byte", {24'd0, mem_z[i]}, {24'd0, r0_vec[127 - 8*i -: 8]});
`ifdef ARK_KEY_CHECKSUM_EN
        chk("nr0 key_xsum", {24'd0, key_xsum_z}, 32'd0);
`endif

        for (int t = 0; t < 4; t++) run_pass(tbl[t]);

        // reset during a round-2 write, then a clean pass
        @(negedge clk); start = 1'b1; xf_ack = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("write cycle before reset", {31'd0, st_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("outputs after mid reset", {busy, done, st_rd, st_we, key_rd, xf_req, st_addr, st_waddr,
                                        st_wdata, key_addr, xf_round}, 32'd0);
        chk("state after mid reset", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0; xf_ack = 1'b0;
        run_pass(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
